// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
//   fetch_state_t : fetch controller states
//   fetch_entry_t : one buffered instruction {pc, inst}
//   FETCH_DEPTH   : default instruction FIFO depth
//   FETCH_TIMEOUT : default REQ cycles allowed without imem_ack (0 = no limit)
package fetch_pkg;

  localparam int FETCH_DEPTH   = 2;
  localparam int FETCH_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ADV  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer holding fetched {pc, inst} entries.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   push, push_data  : write one 64-bit entry (ignored when full)
//   pop              : remove the head entry (ignored when empty)
//   clear            : empty the buffer; wins over push and pop
//   head             : entry at the read pointer
//   count/empty/full : occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [63:0]                push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [63:0]                head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-cycle instruction fetch with req/ack memory port,
// an instruction FIFO towards decode, branch flush and fault reporting.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   pc_addr             : current PC
//   flush               : branch redirect, drops buffered and in-flight fetches
//   imem_req/imem_addr  : memory read request and its (stable) address
//   imem_ack/imem_rdata : memory read completion and instruction word
//   inst_valid/inst/inst_pc/inst_ready : FIFO head handshake to decode
//   pc_advance          : one-cycle PC register load enable
//   fetch_fault         : sticky misaligned-PC / memory-timeout fault
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | check PC alignment, issue a read when the FIFO has room
// REQ   | imem_req high, waiting for ack (timeout runs here)
// ADV   | instruction pushed, pulse pc_advance
// HALT  | fault seen, no more requests; FIFO still drains
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH   = FETCH_DEPTH,
  parameter int TIMEOUT = FETCH_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        pc_advance,
  output logic        fetch_fault
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  // Down-counter loaded at issue; terminal count 0 marks the last allowed REQ cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  fetch_state_t     state, state_nxt;
  logic             drop;
  logic [TMO_W-1:0] tmo_cnt;
  logic             issue;
  logic             push;
  logic             pop;
  logic             set_drop;
  logic             fault_set;
  logic             tmo_dec;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [63:0]      fifo_head;
  fetch_entry_t     head_e;
  fetch_entry_t     push_e;

  assign push_e     = '{pc: imem_addr, inst: imem_rdata};
  assign head_e     = fetch_entry_t'(fifo_head);
  assign inst       = head_e.inst;
  assign inst_pc    = head_e.pc;
  assign inst_valid = !fifo_empty;
  assign pop        = !fifo_empty && inst_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_e),
    .pop       (pop),
    .clear     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    push       = 1'b0;
    set_drop   = 1'b0;
    fault_set  = 1'b0;
    tmo_dec    = 1'b0;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pc_addr[1:0] != 2'b00) begin
          state_nxt = ST_HALT;
          fault_set = 1'b1;
        end else if ((fifo_count < CNT_W'(DEPTH)) && !flush) begin
          issue     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // The handshake cannot be abandoned: a flush only marks the data for discard.
        imem_req = 1'b1;
        if (imem_ack) begin
          if (!drop && !flush) begin
            push      = !fifo_full;
            state_nxt = ST_ADV;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          set_drop = flush;
          if (TMO_EN) begin
            if (tmo_cnt == '0) begin
              state_nxt = ST_HALT;
              fault_set = 1'b1;
            end else begin
              tmo_dec = 1'b1;
            end
          end
        end
      end
      ST_ADV: begin
        // Pulses even under flush; the PC stage gives the redirect priority.
        pc_advance = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      imem_addr   <= '0;
      drop        <= 1'b0;
      tmo_cnt     <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        imem_addr <= pc_addr;
        drop      <= 1'b0;
        tmo_cnt   <= TMO_LAST;
      end else begin
        if (set_drop) drop <= 1'b1;
        if (tmo_dec) tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (fault_set) fetch_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;
  localparam int TMO   = 16;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        pc_advance;
  logic        fetch_fault;

  inst_fetch_unit #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .pc_advance (pc_advance),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs
  logic        drv_ack, drv_flush, drv_ready;
  logic [31:0] drv_rdata, drv_target;
  logic [31:0] pc;

  // behavioural model: a fetch is "outstanding" or a pc step is "owed",
  // buffered instructions live in a queue
  bit          m_busy, m_adv, m_drop, m_halt;
  int          m_age;
  logic [31:0] m_addr;
  logic [63:0] mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_adv = 0; m_drop = 0; m_halt = 0; m_age = 0; m_addr = '0;
    mq.delete();
  endtask

  task automatic model_step();
    logic [63:0] push_e;
    bit do_push, adv_was, popd;
    adv_was = m_adv;
    do_push = 0;
    push_e  = '0;
    popd    = (mq.size() != 0) && drv_ready;
    if (m_halt) begin
    end else if (m_busy) begin
      if (drv_ack) begin
        m_busy = 0;
        if (!m_drop && !drv_flush) begin
          do_push = 1;
          push_e  = {m_addr, drv_rdata};
          m_adv   = 1;
        end
      end else begin
        if (drv_flush) m_drop = 1;
        m_age++;
        if (TMO != 0 && m_age == TMO) begin
          m_busy = 0;
          m_halt = 1;
        end
      end
    end else if (m_adv) begin
      m_adv = 0;
    end else if (pc[1:0] != 2'b00) begin
      m_halt = 1;
    end else if (mq.size() < DEPTH && !drv_flush) begin
      m_busy = 1; m_addr = pc; m_drop = 0; m_age = 0;
    end
    if (drv_flush) mq.delete();
    else begin
      if (popd) void'(mq.pop_front());
      if (do_push) mq.push_back(push_e);
    end
    if (drv_flush) pc = drv_target;
    else if (adv_was) pc = pc + 32'd4;
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
    chk("pc_advance", {31'd0, pc_advance}, {31'd0, m_adv});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_halt});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
    if (m_busy) chk("imem_addr", imem_addr, m_addr);
    if (mq.size() != 0) begin
      chk("inst", inst, mq[0][31:0]);
      chk("inst_pc", inst_pc, mq[0][63:32]);
    end
  endtask

  // called at a falling edge; returns at the next falling edge after checking
  task automatic step();
    pc_addr    = pc;
    flush      = drv_flush;
    imem_ack   = drv_ack;
    imem_rdata = drv_rdata;
    inst_ready = drv_ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b0;
    model_reset();
    pc = start_pc;
    drv_ack = 0; drv_flush = 0; drv_ready = 1; drv_rdata = '0; drv_target = '0;
    pc_addr = pc; flush = 0; imem_ack = 0; imem_rdata = '0; inst_ready = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst pc_advance", {31'd0, pc_advance}, 32'd0);
    chk("rst fetch_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst imem_addr", imem_addr, 32'd0);
    chk("rst inst", inst, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
  endtask

  int req_cnt;
  logic [31:0] t;

  initial begin
    rst = 1'b0;
    model_reset();

    // basic fetch
    do_reset(32'h0);
    step();
    chk("basic req", {31'd0, imem_req}, 32'd1);
    drv_rdata = 32'h20010005;
    step();
    drv_ack = 1;
    step();
    chk("basic valid", {31'd0, inst_valid}, 32'd1);
    chk("basic inst", inst, 32'h20010005);
    chk("basic inst_pc", inst_pc, 32'h0);
    chk("basic adv", {31'd0, pc_advance}, 32'd1);
    drv_ack = 0;
    step();
    chk("basic valid gone", {31'd0, inst_valid}, 32'd0);
    chk("basic adv gone", {31'd0, pc_advance}, 32'd0);

    // backpressure
    do_reset(32'h0);
    drv_ready = 0; drv_ack = 1; drv_rdata = 32'h11112222;
    req_cnt = 0;
    repeat (10) begin step(); if (imem_req) req_cnt++; end
    chk("bp req cycles", req_cnt, 32'd2);
    chk("bp head pc", inst_pc, 32'h0);
    drv_ready = 1; drv_ack = 0;
    step();
    chk("bp second pc", inst_pc, 32'h4);
    step();
    chk("bp drained", {31'd0, inst_valid}, 32'd0);
    chk("bp resume req", {31'd0, imem_req}, 32'd1);
    chk("bp resume addr", imem_addr, 32'h8);

    // flush in flight
    do_reset(32'h40);
    step();
    step();
    drv_flush = 1; drv_target = 32'h40;
    step();
    drv_flush = 0;
    step();
    drv_ack = 1; drv_rdata = 32'hDEADBEEF;
    step();
    chk("flush valid", {31'd0, inst_valid}, 32'd0);
    chk("flush adv", {31'd0, pc_advance}, 32'd0);
    chk("flush idle", {31'd0, imem_req}, 32'd0);
    drv_ack = 0;
    step();
    chk("flush no adv", {31'd0, pc_advance}, 32'd0);

    // misaligned PC
    do_reset(32'h2);
    step();
    chk("mis fault", {31'd0, fetch_fault}, 32'd1);
    req_cnt = 0;
    repeat (5) begin step(); if (imem_req) req_cnt++; end
    chk("mis no req", req_cnt, 32'd0);
    chk("mis sticky", {31'd0, fetch_fault}, 32'd1);

    // timeout, FIFO still drains afterwards
    do_reset(32'h100);
    drv_ready = 0; drv_ack = 1; drv_rdata = 32'hCAFE0001;
    repeat (3) step();
    drv_ack = 0;
    req_cnt = 0;
    repeat (25) begin step(); if (imem_req) req_cnt++; end
    chk("tmo req cycles", req_cnt, 32'd16);
    chk("tmo fault", {31'd0, fetch_fault}, 32'd1);
    chk("tmo head pc", inst_pc, 32'h100);
    chk("tmo head inst", inst, 32'hCAFE0001);
    drv_ready = 1;
    step();
    chk("tmo drained", {31'd0, inst_valid}, 32'd0);

    // async reset in the middle of REQ
    do_reset(32'h200);
    drv_ready = 0; drv_ack = 1;
    repeat (3) step();
    drv_ack = 0;
    repeat (2) step();
    chk("ar pre req", {31'd0, imem_req}, 32'd1);
    chk("ar pre valid", {31'd0, inst_valid}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("ar req", {31'd0, imem_req}, 32'd0);
    chk("ar valid", {31'd0, inst_valid}, 32'd0);
    chk("ar adv", {31'd0, pc_advance}, 32'd0);
    model_reset();
    pc = 32'h300; pc_addr = pc; drv_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar restart req", {31'd0, imem_req}, 32'd1);
    chk("ar restart addr", imem_addr, 32'h300);

    // randomized traffic
    for (int seg = 0; seg < 3; seg++) begin
      t = $urandom_range(0, 1023);
      t[1:0] = 2'b00;
      do_reset(t);
      for (int c = 0; c < 1500; c++) begin
        drv_ready = ($urandom_range(0, 99) < 70);
        drv_ack   = m_busy && ($urandom_range(0, 99) < 40);
        drv_rdata = $urandom;
        drv_flush = ($urandom_range(0, 99) < 5);
        t = $urandom;
        if ($urandom_range(0, 199) != 0) t[1:0] = 2'b00;
        drv_target = t;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Multi-cycle instruction fetch stage of the single-cycle processor datapath. It consumes the PC value from the next-address logic, issues a request/acknowledge read to instruction memory, and buffers returned instructions with their PC in a small FIFO for decode. It drives `pc_advance` to tell the PC register when to step. It supports flushing on taken branches and reports misaligned-fetch and memory-timeout faults.

## Interface
- `DEPTH`, 2: instruction FIFO entries (≥1).
- `TIMEOUT`, 16: maximum REQ cycles without `imem_ack` before fault; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_addr` in 32: current PC from the next-address logic.
- `flush` in 1: branch redirect; discard buffered and in-flight instructions.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 32: read address, held stable while `imem_req`=1.
- `imem_ack` in 1: read data valid on `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: FIFO head valid.
- `inst` out 32: FIFO head instruction.
- `inst_pc` out 32: FIFO head PC.
- `inst_ready` in 1: decode accepts the head.
- `pc_advance` out 1: one-cycle enable telling the PC register to load its next value.
- `fetch_fault` out 1: sticky fault flag.

## Operation
- FSM states: IDLE, REQ, ADV, HALT.
- **IDLE**
  - If `pc_addr[1:0]`≠0: go to HALT and set `fetch_fault`.
  - Else if FIFO count < DEPTH and `flush`=0: latch `imem_addr`←`pc_addr`, clear `drop`, clear the timeout counter, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `imem_req`=1.
  - On `imem_ack`:
    - If `drop`=0 and `flush`=0: push {`imem_addr`, `imem_rdata`} and go to ADV.
    - Otherwise discard the data and go to IDLE.
  - Without ack: increment the counter. When the counter reaches TIMEOUT (TIMEOUT≠0), go to HALT and set `fetch_fault`.
- **ADV**: `pc_advance`=1 for exactly one cycle, then IDLE.
- **HALT**: all requests stop; the FIFO still drains to decode. Exit only on reset.
- **`flush`**
  - Empties the FIFO on the next edge.
  - In REQ, sets `drop`. `imem_req` stays high until ack, because the memory handshake may not be abandoned.
  - In ADV, `pc_advance` still pulses; the PC stage gives the redirect priority.
- **FIFO**
  - Pop when `inst_valid`&`inst_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - `flush` beats both push and pop in the same cycle.
  - At most one request is outstanding and it is issued only when count < DEPTH, so a push never overflows.
  - Read/write pointers wrap modulo DEPTH; the count width is $clog2(DEPTH+1).
- **Reset values**
  - State IDLE.
  - `imem_req`, `pc_advance`, `fetch_fault`, `inst_valid` = 0.
  - `imem_addr` = 0.
  - FIFO storage zero, so `inst` and `inst_pc` = 0.
  - Reset in any state, including mid-REQ, aborts immediately. Memory must tolerate request withdrawal on reset.

## Timing
- Best-case throughput: one instruction per 3 cycles (IDLE→REQ with same-cycle ack→ADV).
- `imem_req` is high from the cycle after IDLE issue until the cycle `imem_ack` is sampled, inclusive.
- A pushed instruction appears on `inst_valid` in the cycle after the ack edge, which is the same cycle `pc_advance` is high.
- The PC updates at the end of ADV, so the next IDLE sees the new `pc_addr`.
- `fetch_fault` rises in the cycle after the fault condition is detected. It is registered and stays high.
- Timeout: with TIMEOUT=16 and no ack, REQ lasts 16 cycles and HALT starts on the 17th.

## Structure
- Shared package `fetch_pkg`:
  - State enum (IDLE, REQ, ADV, HALT).
  - Default DEPTH/TIMEOUT constants.
  - FIFO entry struct {pc[31:0], inst[31:0]}.
- One sub-module: `fetch_fifo` (parameterised DEPTH, 64-bit entries, push/pop/clear, count/empty/full outputs).
- FSM, timeout counter and `drop` flag live in the top level.

## Test plan
- **Basic fetch:** reset release, `pc_addr`=0x00000000, ack one cycle after req with 0x20010005, `inst_ready`=1 → `inst_valid` for 1 cycle with `inst`=0x20010005, `inst_pc`=0; single `pc_advance` pulse.
- **Backpressure:** `inst_ready`=0, PC steps 0x0→0x4 → two entries buffered, no third `imem_req`. Raise `inst_ready` → 0x0 popped before 0x4, fetching resumes.
- **Flush in flight:** `flush` in the second REQ cycle, ack with 0xDEADBEEF on the fourth → data not pushed, no `pc_advance`, `inst_valid`=0, returns to IDLE.
- **Misaligned PC:** `pc_addr`=0x00000002 → `fetch_fault`=1 next cycle, `imem_req` never asserted, fault persists until `rst` low.
- **Timeout:** TIMEOUT=16, ack held low → `imem_req` high exactly 16 cycles, `fetch_fault` set the following cycle; FIFO contents still drain.
- **Async reset mid-REQ:** `rst` low between clock edges → `imem_req`, `inst_valid`, `pc_advance` drop to 0 without a clock edge; fetch restarts from `pc_addr` after release.
